timekeeper_ctrl: RTL and testbench

Front-panel controller for the timer/stopwatch/clock/alarm timekeeping datapath. It debounces the three raw panel buttons, owns the 4-state mode register, and decodes presses into single-cycle command strobes for the datapath. It also tracks the stopwatch lap slot index and schedules the shared ring output between timer-expiry and clock-alarm events, including acknowledge and auto-silence.

---
 rtl/timekeeper_pkg.sv | 36 +++
 rtl/timekeeper_if.sv | 42 ++++
 rtl/button_debounce.sv | 55 +++++
 rtl/timekeeper_ctrl.sv | 178 +++++++++++++++++
 tb/tb_timekeeper_ctrl.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/timekeeper_pkg.sv
// timekeeper_pkg
//   Encodings shared by the front-panel controller and the timekeeping
//   datapath: mode codes, ringSource bit positions, lap-slot count, ring
//   FSM state codes and button lane indices.
package timekeeper_pkg;

   typedef enum logic [1:0] {
      TIMER     = 2'd0,
      STOPWATCH = 2'd1,
      CLOCK     = 2'd2,
      ALARM     = 2'd3
   } modeT;

   typedef enum logic {
      RING_IDLE   = 1'b0,
      RING_ACTIVE = 1'b1
   } ringStateT;

   // Bit positions inside ringSource
   localparam int RING_SRC_TIMER = 0;
   localparam int RING_SRC_ALARM = 1;

   localparam int MAX_LAPS_DEFAULT = 10;

   // Lane of each panel button in the debouncer bank
   localparam int BTN_MODE  = 0;
   localparam int BTN_SET   = 1;
   localparam int BTN_SPLIT = 2;
   localparam int NUM_BTNS  = 3;

   // Mode sequence TIMER -> STOPWATCH -> CLOCK -> ALARM -> TIMER (mod 4)
   function automatic modeT nextMode(input modeT m);
      return modeT'(m + 2'd1);
   endfunction

endpackage

// File: rtl/timekeeper_if.sv
// timekeeper_if
//   Controller <-> datapath bundle.
//   master (controller): drives mode, command strobes, lap and ring outputs;
//                        receives run status levels and event pulses.
//   slave  (datapath)  : the mirror image.
interface timekeeper_if;

   // datapath status / events
   logic       timerRunning;
   logic       stopwatchRunning;
   logic       timerExpired;
   logic       alarmMatch;

   // controller outputs
   logic [1:0] mode;
   logic       cmdTimerStart;
   logic       cmdTimerCancel;
   logic       cmdSwToggle;
   logic       cmdLap;
   logic       cmdLapClear;
   logic       cmdClockLoad;
   logic       cmdAlarmLoad;
   logic [3:0] lapIndex;
   logic       lapFull;
   logic       ringSound;
   logic [1:0] ringSource;

   modport master (
      input  timerRunning, stopwatchRunning, timerExpired, alarmMatch,
      output mode, cmdTimerStart, cmdTimerCancel, cmdSwToggle, cmdLap,
             cmdLapClear, cmdClockLoad, cmdAlarmLoad, lapIndex, lapFull,
             ringSound, ringSource
   );

   modport slave (
      output timerRunning, stopwatchRunning, timerExpired, alarmMatch,
      input  mode, cmdTimerStart, cmdTimerCancel, cmdSwToggle, cmdLap,
             cmdLapClear, cmdClockLoad, cmdAlarmLoad, lapIndex, lapFull,
             ringSound, ringSource
   );

endinterface

// File: rtl/button_debounce.sv
// button_debounce
//   Two-flop synchroniser followed by a stable-sample counter. The accepted
//   level only changes after DEBOUNCE_CYCLES consecutive samples disagree
//   with it; a rising acceptance emits a one-cycle pressPulse.
//   Ports: clockSignal, startOrStop (async reset, active-high),
//          rawBtn (asynchronous, high = pressed), pressPulse (1 cycle).
module button_debounce #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clockSignal,
   input  logic startOrStop,
   input  logic rawBtn,
   output logic pressPulse
);

   localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             syncMetaReg;
   logic             syncLevelReg;
   logic             pressedReg;
   logic             pulseReg;
   logic [CNT_W-1:0] stableCntReg;

   // Reset parks everything in the "pressed" state so that a button held
   // through reset release must be seen low for DEBOUNCE_CYCLES samples
   // before a fresh press can be accepted.
   always_ff @(posedge clockSignal or posedge startOrStop) begin
      if (startOrStop) begin
         syncMetaReg  <= 1'b1;
         syncLevelReg <= 1'b1;
         pressedReg   <= 1'b1;
         pulseReg     <= 1'b0;
         stableCntReg <= '0;
      end else begin
         syncMetaReg  <= rawBtn;
         syncLevelReg <= syncMetaReg;
         pulseReg     <= 1'b0;
         if (syncLevelReg != pressedReg) begin
            if (stableCntReg == CNT_LAST) begin
               pressedReg   <= syncLevelReg;
               pulseReg     <= syncLevelReg;
               stableCntReg <= '0;
            end else begin
               stableCntReg <= stableCntReg + CNT_W'(1);
            end
         end else begin
            stableCntReg <= '0;
         end
      end
   end

   assign pressPulse = pulseReg;

endmodule

// File: rtl/timekeeper_ctrl.sv
// timekeeper_ctrl
//   Front-panel controller: debounces modeBtn/setBtn/splitBtn, owns the
//   mode register, decodes presses into one-cycle datapath command strobes,
//   tracks the stopwatch lap slot and runs the shared ring FSM.
//   Ports: clockSignal (100 Hz), startOrStop (async reset, active-high),
//          modeBtn/setBtn/splitBtn (raw buttons),
//          dp (timekeeper_if.master: status in, mode/cmd/lap/ring out).
module timekeeper_ctrl
   import timekeeper_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int RING_CYCLES     = 3000,
   parameter int MAX_LAPS        = MAX_LAPS_DEFAULT
) (
   input  logic         clockSignal,
   input  logic         startOrStop,
   input  logic         modeBtn,
   input  logic         setBtn,
   input  logic         splitBtn,
   timekeeper_if.master dp
);

   localparam int                 RING_W      = $clog2(RING_CYCLES);
   localparam logic [RING_W-1:0]  RING_RELOAD = RING_W'(RING_CYCLES - 1);
   localparam logic [3:0]         LAP_LIMIT   = 4'(MAX_LAPS);

   // ---------------- debouncer bank ----------------
   logic [NUM_BTNS-1:0] rawBtns;
   logic [NUM_BTNS-1:0] pressPulse;

   assign rawBtns[BTN_MODE]  = modeBtn;
   assign rawBtns[BTN_SET]   = setBtn;
   assign rawBtns[BTN_SPLIT] = splitBtn;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_BTNS; gi++) begin : genDebounce
         button_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
         ) uDebounce (
            .clockSignal (clockSignal),
            .startOrStop (startOrStop),
            .rawBtn      (rawBtns[gi]),
            .pressPulse  (pressPulse[gi])
         );
      end
   endgenerate

   // ---------------- state ----------------
   modeT              modeReg;
   ringStateT         ringStateReg;
   logic [RING_W-1:0] ringCntReg;
   logic [1:0]        ringSourceReg;
   logic              ringSoundReg;
   logic [3:0]        lapIndexReg;
   logic              cmdTimerStartReg, cmdTimerCancelReg, cmdSwToggleReg;
   logic              cmdLapReg, cmdLapClearReg, cmdClockLoadReg, cmdAlarmLoadReg;

   logic       modePress, setPress, splitPress, anyPress;
   logic       ringing, ringEvent, ackNow, lapFullNow;
   logic [1:0] eventBits;

   assign modePress  = pressPulse[BTN_MODE];
   assign setPress   = pressPulse[BTN_SET];
   assign splitPress = pressPulse[BTN_SPLIT];
   assign anyPress   = |pressPulse;
   assign ringing    = (ringStateReg == RING_ACTIVE);
   assign ringEvent  = dp.timerExpired | dp.alarmMatch;
   assign ackNow     = ringing & anyPress;
   assign lapFullNow = (lapIndexReg == LAP_LIMIT);

   always_comb begin
      eventBits                 = '0;
      eventBits[RING_SRC_TIMER] = dp.timerExpired;
      eventBits[RING_SRC_ALARM] = dp.alarmMatch;
   end

   always_ff @(posedge clockSignal or posedge startOrStop) begin
      if (startOrStop) begin
         modeReg           <= TIMER;
         ringStateReg      <= RING_IDLE;
         ringCntReg        <= '0;
         ringSourceReg     <= '0;
         ringSoundReg      <= 1'b0;
         lapIndexReg       <= '0;
         cmdTimerStartReg  <= 1'b0;
         cmdTimerCancelReg <= 1'b0;
         cmdSwToggleReg    <= 1'b0;
         cmdLapReg         <= 1'b0;
         cmdLapClearReg    <= 1'b0;
         cmdClockLoadReg   <= 1'b0;
         cmdAlarmLoadReg   <= 1'b0;
      end else begin
         cmdTimerStartReg  <= 1'b0;
         cmdTimerCancelReg <= 1'b0;
         cmdSwToggleReg    <= 1'b0;
         cmdLapReg         <= 1'b0;
         cmdLapClearReg    <= 1'b0;
         cmdClockLoadReg   <= 1'b0;
         cmdAlarmLoadReg   <= 1'b0;

         // Ring FSM: an event always wins over a simultaneous acknowledge.
         case (ringStateReg)
            RING_IDLE: begin
               if (ringEvent) begin
                  ringStateReg  <= RING_ACTIVE;
                  ringSourceReg <= eventBits;
                  ringCntReg    <= RING_RELOAD;
                  ringSoundReg  <= 1'b1;
               end
            end
            RING_ACTIVE: begin
               if (ringEvent) begin
                  ringSourceReg <= ringSourceReg | eventBits;
                  ringCntReg    <= RING_RELOAD;
               end else if (ackNow || ringCntReg == '0) begin
                  ringStateReg  <= RING_IDLE;
                  ringSourceReg <= '0;
                  ringSoundReg  <= 1'b0;
               end else begin
                  ringCntReg    <= ringCntReg - RING_W'(1);
               end
            end
            default: begin
               ringStateReg <= RING_IDLE;
            end
         endcase

         // While ringing every press is swallowed as the acknowledge.
         if (!ringing) begin
            if (modePress) begin
               modeReg <= nextMode(modeReg);
            end else if (setPress) begin
               case (modeReg)
                  TIMER: begin
                     if (dp.timerRunning) cmdTimerCancelReg <= 1'b1;
                     else                 cmdTimerStartReg  <= 1'b1;
                  end
                  STOPWATCH: cmdSwToggleReg  <= 1'b1;
                  CLOCK:     ;
                  ALARM:     cmdAlarmLoadReg <= 1'b1;
                  default:   ;
               endcase
            end else if (splitPress) begin
               case (modeReg)
                  TIMER: cmdTimerCancelReg <= 1'b1;
                  STOPWATCH: begin
                     if (!dp.stopwatchRunning) begin
                        cmdLapClearReg <= 1'b1;
                        lapIndexReg    <= '0;
                     end else if (!lapFullNow) begin
                        cmdLapReg      <= 1'b1;
                        lapIndexReg    <= lapIndexReg + 4'd1;
                     end
                  end
                  CLOCK:   cmdClockLoadReg <= 1'b1;
                  ALARM:   cmdAlarmLoadReg <= 1'b1;
                  default: ;
               endcase
            end
         end
      end
   end

   assign dp.mode           = modeReg;
   assign dp.cmdTimerStart  = cmdTimerStartReg;
   assign dp.cmdTimerCancel = cmdTimerCancelReg;
   assign dp.cmdSwToggle    = cmdSwToggleReg;
   assign dp.cmdLap         = cmdLapReg;
   assign dp.cmdLapClear    = cmdLapClearReg;
   assign dp.cmdClockLoad   = cmdClockLoadReg;
   assign dp.cmdAlarmLoad   = cmdAlarmLoadReg;
   assign dp.lapIndex       = lapIndexReg;
   assign dp.lapFull        = lapFullNow;
   assign dp.ringSound      = ringSoundReg;
   assign dp.ringSource     = ringSourceReg;

endmodule

// File: tb/tb_timekeeper_ctrl.sv
// tb_timekeeper_ctrl
//   Directed bench for timekeeper_ctrl (DEBOUNCE_CYCLES=4, RING_CYCLES=3000,
//   MAX_LAPS=10). One task per scenario, inline comparisons.
module tb_timekeeper_ctrl;

   logic clockSignal = 1'b0;
   logic startOrStop = 1'b1;
   logic modeBtn     = 1'b0;
   logic setBtn      = 1'b0;
   logic splitBtn    = 1'b0;

   int checks = 0;
   int errors = 0;

   // strobe tallies seen on the falling edge
   int nStart = 0, nCancel = 0, nToggle = 0, nLap = 0, nClear = 0;
   int nClockLoad = 0, nAlarmLoad = 0;

   timekeeper_if dp ();

   timekeeper_ctrl #(
      .DEBOUNCE_CYCLES(4),
      .RING_CYCLES    (3000),
      .MAX_LAPS       (10)
   ) dut (
      .clockSignal (clockSignal),
      .startOrStop (startOrStop),
      .modeBtn     (modeBtn),
      .setBtn      (setBtn),
      .splitBtn    (splitBtn),
      .dp          (dp)
   );

   always #5 clockSignal = ~clockSignal;

   always @(negedge clockSignal) begin
      if (dp.cmdTimerStart)  nStart++;
      if (dp.cmdTimerCancel) nCancel++;
      if (dp.cmdSwToggle)    nToggle++;
      if (dp.cmdLap)         nLap++;
      if (dp.cmdLapClear)    nClear++;
      if (dp.cmdClockLoad)   nClockLoad++;
      if (dp.cmdAlarmLoad)   nAlarmLoad++;
   end

   function automatic int totalStrobes();
      return nStart + nCancel + nToggle + nLap + nClear + nClockLoad + nAlarmLoad;
   endfunction

   task automatic tick();
      @(posedge clockSignal);
      #1;
   endtask

   // which: 0 mode, 1 set, 2 split. Hold 8 cycles, release 10 cycles.
   task automatic pressBtn(input int which);
      case (which)
         0: modeBtn  = 1'b1;
         1: setBtn   = 1'b1;
         default: splitBtn = 1'b1;
      endcase
      repeat (8) tick();
      modeBtn = 1'b0; setBtn = 1'b0; splitBtn = 1'b0;
      repeat (10) tick();
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if (dp.mode !== 2'd0 || dp.lapIndex !== 4'd0 || dp.lapFull !== 1'b0 ||
          dp.ringSound !== 1'b0 || dp.ringSource !== 2'b00) begin
         errors++;
         $display("FAIL reset_outputs mode=%0d lap=%0d full=%0b ring=%0b src=%b required 0,0,0,0,00",
                  dp.mode, dp.lapIndex, dp.lapFull, dp.ringSound, dp.ringSource);
      end
      repeat (3) tick();
      startOrStop = 1'b0;
      repeat (10) tick();
      checks++;
      if (totalStrobes() !== 0) begin
         errors++;
         $display("FAIL reset_strobes got %0d required 0", totalStrobes());
      end
      $display("reset: mode=%0d lap=%0d ring=%0b", dp.mode, dp.lapIndex, dp.ringSound);
   endtask

   task automatic test_mode_cycle();
      logic [1:0] expMode [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
      int base = totalStrobes();
      for (int i = 0; i < 4; i++) begin
         pressBtn(0);
         checks++;
         if (dp.mode !== expMode[i]) begin
            errors++;
            $display("FAIL mode_step%0d got %0d required %0d", i, dp.mode, expMode[i]);
         end
         $display("mode press %0d: mode=%0d", i, dp.mode);
      end
      checks++;
      if (totalStrobes() !== base) begin
         errors++;
         $display("FAIL mode_no_cmd got %0d strobes required 0", totalStrobes() - base);
      end
      // 3-cycle glitch must be filtered
      modeBtn = 1'b1;
      repeat (3) tick();
      modeBtn = 1'b0;
      repeat (12) tick();
      checks++;
      if (dp.mode !== 2'd0) begin
         errors++;
         $display("FAIL mode_glitch got %0d required 0", dp.mode);
      end
      $display("glitch: mode=%0d", dp.mode);
   endtask

   task automatic test_timer_cmds();
      int s0, c0;
      dp.timerRunning = 1'b0;
      s0 = nStart;
      c0 = nCancel;
      setBtn = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         tick();
         checks++;
         if (dp.cmdTimerStart !== (k == 7)) begin
            errors++;
            $display("FAIL timer_start_latency cycle %0d got %0b required %0b",
                     k, dp.cmdTimerStart, (k == 7));
         end
      end
      setBtn = 1'b0;
      repeat (10) tick();
      checks++;
      if (nStart - s0 !== 1 || nCancel !== c0) begin
         errors++;
         $display("FAIL timer_start_count start=%0d cancel=%0d required 1,0",
                  nStart - s0, nCancel - c0);
      end
      $display("timer start: strobes start=%0d", nStart - s0);
      dp.timerRunning = 1'b1;
      pressBtn(1);
      checks++;
      if (nCancel - c0 !== 1 || nStart - s0 !== 1) begin
         errors++;
         $display("FAIL timer_cancel_count cancel=%0d start=%0d required 1,1",
                  nCancel - c0, nStart - s0);
      end
      $display("timer running set: cancel=%0d", nCancel - c0);
      dp.timerRunning = 1'b0;
   endtask

   task automatic test_laps();
      int l0, cl0;
      int expIdx;
      pressBtn(0);                 // TIMER -> STOPWATCH
      checks++;
      if (dp.mode !== 2'd1) begin
         errors++;
         $display("FAIL lap_mode got %0d required 1", dp.mode);
      end
      dp.stopwatchRunning = 1'b1;
      l0 = nLap;
      for (int i = 1; i <= 11; i++) begin
         pressBtn(2);
         expIdx = (i > 10) ? 10 : i;
         checks++;
         if (dp.lapIndex !== 4'(expIdx) || nLap - l0 !== expIdx) begin
            errors++;
            $display("FAIL lap_press%0d idx=%0d laps=%0d required %0d,%0d",
                     i, dp.lapIndex, nLap - l0, expIdx, expIdx);
         end
         $display("lap press %0d: lapIndex=%0d full=%0b", i, dp.lapIndex, dp.lapFull);
      end
      checks++;
      if (dp.lapFull !== 1'b1) begin
         errors++;
         $display("FAIL lap_full got %0b required 1", dp.lapFull);
      end
      dp.stopwatchRunning = 1'b0;
      cl0 = nClear;
      pressBtn(2);
      checks++;
      if (nClear - cl0 !== 1 || dp.lapIndex !== 4'd0 || dp.lapFull !== 1'b0) begin
         errors++;
         $display("FAIL lap_clear clears=%0d idx=%0d full=%0b required 1,0,0",
                  nClear - cl0, dp.lapIndex, dp.lapFull);
      end
      $display("lap clear: lapIndex=%0d", dp.lapIndex);
   endtask

   task automatic test_ring_timeout();
      int highCycles;
      dp.timerExpired = 1'b1;
      tick();
      dp.timerExpired = 1'b0;
      checks++;
      if (dp.ringSound !== 1'b1 || dp.ringSource !== 2'b01) begin
         errors++;
         $display("FAIL ring_start sound=%0b src=%b required 1,01", dp.ringSound, dp.ringSource);
      end
      highCycles = 1;
      for (int k = 0; k < 3100; k++) begin
         tick();
         if (dp.ringSound) highCycles++;
         else break;
      end
      checks++;
      if (highCycles !== 3000 || dp.ringSound !== 1'b0 || dp.ringSource !== 2'b00) begin
         errors++;
         $display("FAIL ring_timeout cycles=%0d sound=%0b src=%b required 3000,0,00",
                  highCycles, dp.ringSound, dp.ringSource);
      end
      $display("ring timeout: high for %0d cycles", highCycles);
   endtask

   task automatic test_ring_ack();
      int t0 = nToggle;
      dp.alarmMatch = 1'b1;
      tick();
      dp.alarmMatch = 1'b0;
      checks++;
      if (dp.ringSound !== 1'b1 || dp.ringSource !== 2'b10) begin
         errors++;
         $display("FAIL ring_alarm sound=%0b src=%b required 1,10", dp.ringSound, dp.ringSource);
      end
      repeat (10) tick();
      dp.timerExpired = 1'b1;
      tick();
      dp.timerExpired = 1'b0;
      checks++;
      if (dp.ringSound !== 1'b1 || dp.ringSource !== 2'b11) begin
         errors++;
         $display("FAIL ring_both sound=%0b src=%b required 1,11", dp.ringSound, dp.ringSource);
      end
      pressBtn(1);
      checks++;
      if (dp.ringSound !== 1'b0 || dp.ringSource !== 2'b00 || dp.mode !== 2'd1 ||
          nToggle !== t0) begin
         errors++;
         $display("FAIL ring_ack sound=%0b src=%b mode=%0d toggles=%0d required 0,00,1,0",
                  dp.ringSound, dp.ringSource, dp.mode, nToggle - t0);
      end
      $display("ring ack: sound=%0b mode=%0d", dp.ringSound, dp.mode);
   endtask

   task automatic test_async_reset();
      dp.stopwatchRunning = 1'b1;
      repeat (5) pressBtn(2);
      dp.stopwatchRunning = 1'b0;
      pressBtn(0);
      pressBtn(0);                 // STOPWATCH -> CLOCK -> ALARM
      dp.timerExpired = 1'b1;
      tick();
      dp.timerExpired = 1'b0;
      tick();
      checks++;
      if (dp.mode !== 2'd3 || dp.lapIndex !== 4'd5 || dp.ringSound !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset mode=%0d idx=%0d sound=%0b required 3,5,1",
                  dp.mode, dp.lapIndex, dp.ringSound);
      end
      #2 startOrStop = 1'b1;
      #1;
      checks++;
      if (dp.mode !== 2'd0 || dp.lapIndex !== 4'd0 || dp.ringSound !== 1'b0 ||
          dp.ringSource !== 2'b00) begin
         errors++;
         $display("FAIL async_reset mode=%0d idx=%0d sound=%0b src=%b required 0,0,0,00",
                  dp.mode, dp.lapIndex, dp.ringSound, dp.ringSource);
      end
      $display("async reset: mode=%0d idx=%0d sound=%0b", dp.mode, dp.lapIndex, dp.ringSound);
      repeat (2) tick();
      startOrStop = 1'b0;
      repeat (10) tick();
   endtask

   initial begin
      dp.timerRunning     = 1'b0;
      dp.stopwatchRunning = 1'b0;
      dp.timerExpired     = 1'b0;
      dp.alarmMatch       = 1'b0;
      test_reset();
      test_mode_cycle();
      test_timer_cmds();
      test_laps();
      test_ring_timeout();
      test_ring_ack();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
